soc_arb_rr_wb: RTL and testbench

Round-robin Wishbone arbiter placed directly upstream of the address decoder. It merges MASTERS Wishbone master ports onto the single master port that feeds the decoder. Ownership is locked for the whole cycle while the owner holds cyc. An optional watchdog terminates transfers that never receive ack/err/rty.

---
 rtl/soc_arb_rr_wb_if.sv | 57 +++++
 rtl/soc_arb_rr_wb.sv | 109 ++++++++++
 tb/tb_soc_arb_rr_wb.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_arb_rr_wb_if.sv
// Bus bundle between MASTERS Wishbone masters, the round-robin arbiter and
// the downstream address decoder. The arbiter takes the slave modport; the
// environment driving masters and decoder takes the master modport.
interface soc_arb_rr_wb_if #(
  parameter int MASTERS    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH >> 3;

  // Upstream master ports
  logic [MASTERS-1:0][ADDR_WIDTH-1:0] m_adr_i;
  logic [MASTERS-1:0][DATA_WIDTH-1:0] m_dat_i;
  logic [MASTERS-1:0]                 m_cyc_i;
  logic [MASTERS-1:0]                 m_stb_i;
  logic [MASTERS-1:0][SEL_WIDTH-1:0]  m_sel_i;
  logic [MASTERS-1:0]                 m_we_i;
  logic [MASTERS-1:0][2:0]            m_cti_i;
  logic [MASTERS-1:0][1:0]            m_bte_i;
  logic [MASTERS-1:0][DATA_WIDTH-1:0] m_dat_o;
  logic [MASTERS-1:0]                 m_ack_o;
  logic [MASTERS-1:0]                 m_err_o;
  logic [MASTERS-1:0]                 m_rty_o;

  // Downstream port towards the decoder
  logic [ADDR_WIDTH-1:0]              s_adr_o;
  logic [DATA_WIDTH-1:0]              s_dat_o;
  logic [SEL_WIDTH-1:0]               s_sel_o;
  logic                               s_we_o;
  logic [2:0]                         s_cti_o;
  logic [1:0]                         s_bte_o;
  logic                               s_cyc_o;
  logic                               s_stb_o;
  logic [DATA_WIDTH-1:0]              s_dat_i;
  logic                               s_ack_i;
  logic                               s_err_i;
  logic                               s_rty_i;

  // Current owner, one-hot, zero when idle
  logic [MASTERS-1:0]                 grant_o;

  modport slave (
    input  m_adr_i, m_dat_i, m_cyc_i, m_stb_i, m_sel_i, m_we_i, m_cti_i, m_bte_i,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o,
    output grant_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_cyc_i, m_stb_i, m_sel_i, m_we_i, m_cti_i, m_bte_i,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o,
    input  grant_o
  );
endinterface

// File: rtl/soc_arb_rr_wb.sv
// Round-robin Wishbone arbiter in front of the address decoder. Ownership is
// locked while the owner holds cyc; a handover happens on the same edge the
// owner releases. An optional watchdog errors strobes left unanswered.
module soc_arb_rr_wb #(
  parameter int MASTERS    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input logic             clk_i,
  input logic             rst_i,
  soc_arb_rr_wb_if.slave  bus
);
  localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [MASTERS-1:0] r_grant;
  logic [IDX_W-1:0]   r_last;

  logic               w_active;
  logic [IDX_W-1:0]   w_owner;
  logic               w_released;
  logic               w_found;
  logic [IDX_W-1:0]   w_next_idx;
  logic [MASTERS-1:0] w_next_grant;
  logic               w_timeout_hit;
  logic               w_s_cyc;
  logic               w_s_stb;

  // While a grant is held, r_last is the owner's index; when idle the mux
  // falls back to master 0 so the decoder sees stable fields.
  assign w_active   = |r_grant;
  assign w_owner    = w_active ? r_last : '0;
  assign w_released = !w_active || !bus.m_cyc_i[w_owner];

  // Pick the first requester after the most recent owner, wrapping around.
  always_comb begin
    // NOTE: defaults first so every path assigns each variable and no latch is inferred.
    w_found    = 1'b0;
    w_next_idx = r_last;
    for (int i = 1; i <= MASTERS; i++) begin
      if (!w_found && bus.m_cyc_i[IDX_W'((int'(r_last) + i) % MASTERS)]) begin
        w_found    = 1'b1;
        w_next_idx = IDX_W'((int'(r_last) + i) % MASTERS);
      end
    end
    w_next_grant = w_found ? (MASTERS'(1) << w_next_idx) : '0;
  end

  // Grant and last-owner registers; re-arbitrate only when the owner lets go.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_grant <= '0;
      r_last  <= IDX_W'(MASTERS - 1);
    end else if (w_released) begin
      // NOTE: non-blocking so both registers update from pre-edge values.
      r_grant <= w_next_grant;
      if (w_found) begin
        r_last <= w_next_idx;
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wdog
      logic [CNT_W-1:0] r_wdog_cnt;
      logic             w_term;

      assign w_term = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
      // An ack landing on the expiry cycle wins: no forced error then.
      assign w_timeout_hit = (r_wdog_cnt == CNT_W'(TIMEOUT)) && !bus.s_ack_i;

      // Count cycles an active strobe waits; any gap, reply or expiry restarts.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_wdog_cnt <= '0;
        end else if (w_s_cyc && w_s_stb && !w_term) begin
          r_wdog_cnt <= r_wdog_cnt + CNT_W'(1);
        end else begin
          r_wdog_cnt <= '0;
        end
      end
    end else begin : g_no_wdog
      assign w_timeout_hit = 1'b0;
    end
  endgenerate

  // Gate the owner's cycle/strobe; expiry pulls them low for that one cycle.
  always_comb begin
    w_s_cyc = w_active & bus.m_cyc_i[w_owner] & ~w_timeout_hit;
    w_s_stb = w_active & bus.m_stb_i[w_owner] & ~w_timeout_hit;
  end

  assign bus.s_cyc_o = w_s_cyc;
  assign bus.s_stb_o = w_s_stb;
  assign bus.s_adr_o = bus.m_adr_i[w_owner];
  assign bus.s_dat_o = bus.m_dat_i[w_owner];
  assign bus.s_sel_o = bus.m_sel_i[w_owner];
  assign bus.s_we_o  = bus.m_we_i[w_owner];
  assign bus.s_cti_o = bus.m_cti_i[w_owner];
  assign bus.s_bte_o = bus.m_bte_i[w_owner];

  // Read data is broadcast; terminations reach the owner only.
  assign bus.m_dat_o = {MASTERS{bus.s_dat_i}};
  assign bus.m_ack_o = r_grant & {MASTERS{bus.s_ack_i}};
  assign bus.m_rty_o = r_grant & {MASTERS{bus.s_rty_i}};
  assign bus.m_err_o = r_grant & {MASTERS{bus.s_err_i | w_timeout_hit}};
  assign bus.grant_o = r_grant;
endmodule

// File: tb/tb_soc_arb_rr_wb.sv
// Bench for soc_arb_rr_wb: a 3-master instance with a 4-cycle watchdog and a
// 2-master instance with the watchdog disabled, both checked against an
// owner/last/wait-count model built from the arbitration rules.
module tb_soc_arb_rr_wb;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  soc_arb_rr_wb_if #(.MASTERS(3), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus3 ();
  soc_arb_rr_wb_if #(.MASTERS(2), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  soc_arb_rr_wb #(.MASTERS(3), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(4)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .bus(bus3));
  soc_arb_rr_wb #(.MASTERS(2), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(0)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .bus(bus2));

  int errors = 0;
  int checks = 0;

  // Model state: owner index (-1 idle), last owner, cycles the strobe waited.
  typedef struct { int owner; int last; int wcnt; } mdl_t;
  typedef struct packed {
    logic [15:0] grant; logic scyc; logic sstb;
    logic [15:0] ack; logic [15:0] err; logic [15:0] rty;
  } view_t;

  mdl_t m3, m2;

  function automatic mdl_t mdl_reset(int m);
    mdl_t r;
    r.owner = -1; r.last = m - 1; r.wcnt = 0;
    return r;
  endfunction

  function automatic bit mdl_hit(mdl_t s, int tmo, logic ack);
    return (tmo > 0) && (s.wcnt == tmo) && !ack;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, int m, int tmo, logic [15:0] cyc,
                                    logic [15:0] stb, logic ack, logic err, logic rty);
    mdl_t n = s;
    bit hit = mdl_hit(s, tmo, ack);
    bit waiting = (s.owner >= 0) && cyc[4'(s.owner)] && stb[4'(s.owner)] && !hit
                  && !(ack || err || rty);
    n.wcnt = waiting ? s.wcnt + 1 : 0;
    if (s.owner < 0 || !cyc[4'(s.owner)]) begin
      n.owner = -1;
      for (int k = 1; k <= m; k++) begin
        int c = (s.last + k) % m;
        if (n.owner < 0 && cyc[4'(c)]) begin
          n.owner = c;
          n.last  = c;
        end
      end
    end
    return n;
  endfunction

  function automatic view_t mdl_view(mdl_t s, int tmo, logic [15:0] cyc, logic [15:0] stb,
                                     logic ack, logic err, logic rty);
    view_t v = '0;
    bit hit = mdl_hit(s, tmo, ack);
    if (s.owner >= 0) begin
      v.grant[4'(s.owner)] = 1'b1;
      v.scyc = cyc[4'(s.owner)] && !hit;
      v.sstb = stb[4'(s.owner)] && !hit;
      v.ack[4'(s.owner)] = ack;
      v.err[4'(s.owner)] = err || hit;
      v.rty[4'(s.owner)] = rty;
    end
    return v;
  endfunction

  function automatic view_t exp3();
    return mdl_view(m3, 4, 16'(bus3.m_cyc_i), 16'(bus3.m_stb_i),
                    bus3.s_ack_i, bus3.s_err_i, bus3.s_rty_i);
  endfunction

  function automatic view_t exp2();
    return mdl_view(m2, 0, 16'(bus2.m_cyc_i), 16'(bus2.m_stb_i),
                    bus2.s_ack_i, bus2.s_err_i, bus2.s_rty_i);
  endfunction

  function automatic view_t obs3();
    view_t v;
    v.grant = 16'(bus3.grant_o); v.scyc = bus3.s_cyc_o; v.sstb = bus3.s_stb_o;
    v.ack = 16'(bus3.m_ack_o); v.err = 16'(bus3.m_err_o); v.rty = 16'(bus3.m_rty_o);
    return v;
  endfunction

  function automatic view_t obs2();
    view_t v;
    v.grant = 16'(bus2.grant_o); v.scyc = bus2.s_cyc_o; v.sstb = bus2.s_stb_o;
    v.ack = 16'(bus2.m_ack_o); v.err = 16'(bus2.m_err_o); v.rty = 16'(bus2.m_rty_o);
    return v;
  endfunction

  // Muxed datapath of the 3-master instance: owner fields plus broadcast read data.
  function automatic logic [169:0] dp3_obs();
    return {bus3.s_adr_o, bus3.s_dat_o, bus3.s_sel_o, bus3.s_we_o,
            bus3.s_cti_o, bus3.s_bte_o, bus3.m_dat_o};
  endfunction

  function automatic logic [169:0] dp3_exp();
    logic [1:0] o = (m3.owner < 0) ? 2'd0 : 2'(m3.owner);
    return {bus3.m_adr_i[o], bus3.m_dat_i[o], bus3.m_sel_i[o], bus3.m_we_i[o],
            bus3.m_cti_i[o], bus3.m_bte_i[o], {3{bus3.s_dat_i}}};
  endfunction

  task automatic clear_inputs();
    bus3.m_adr_i = '0; bus3.m_dat_i = '0; bus3.m_cyc_i = '0; bus3.m_stb_i = '0;
    bus3.m_sel_i = '0; bus3.m_we_i = '0; bus3.m_cti_i = '0; bus3.m_bte_i = '0;
    bus3.s_dat_i = '0; bus3.s_ack_i = 1'b0; bus3.s_err_i = 1'b0; bus3.s_rty_i = 1'b0;
    bus2.m_adr_i = '0; bus2.m_dat_i = '0; bus2.m_cyc_i = '0; bus2.m_stb_i = '0;
    bus2.m_sel_i = '0; bus2.m_we_i = '0; bus2.m_cti_i = '0; bus2.m_bte_i = '0;
    bus2.s_dat_i = '0; bus2.s_ack_i = 1'b0; bus2.s_err_i = 1'b0; bus2.s_rty_i = 1'b0;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < 3; i++) begin
      bus3.m_adr_i[i] = $urandom(); bus3.m_dat_i[i] = $urandom();
      bus3.m_sel_i[i] = 4'($urandom()); bus3.m_we_i[i] = 1'($urandom());
      bus3.m_cti_i[i] = 3'($urandom()); bus3.m_bte_i[i] = 2'($urandom());
    end
    for (int i = 0; i < 2; i++) begin
      bus2.m_adr_i[i] = $urandom(); bus2.m_dat_i[i] = $urandom();
    end
    bus3.s_dat_i = $urandom();
    bus2.s_dat_i = $urandom();
  endtask

  // Advance one clock: model steps on the rising edge, stimulus resumes at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m3 = mdl_reset(3);
      m2 = mdl_reset(2);
    end else begin
      m3 = mdl_step(m3, 3, 4, 16'(bus3.m_cyc_i), 16'(bus3.m_stb_i),
                    bus3.s_ack_i, bus3.s_err_i, bus3.s_rty_i);
      m2 = mdl_step(m2, 2, 0, 16'(bus2.m_cyc_i), 16'(bus2.m_stb_i),
                    bus2.s_ack_i, bus2.s_err_i, bus2.s_rty_i);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    m3 = mdl_reset(3);
    m2 = mdl_reset(2);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    m3 = mdl_reset(3);
    m2 = mdl_reset(2);
    bus3.m_adr_i[0] = 32'h1000_0000; bus3.m_adr_i[1] = 32'h2000_0000;
    bus3.m_adr_i[2] = 32'h3000_0000;
    @(negedge clk);
    #1;
    checks++;
    if (bus3.s_adr_o !== 32'h1000_0000) begin
      errors++; $display("FAIL reset_adr got=%h want=%h", bus3.s_adr_o, 32'h1000_0000);
    end
    // Requests and replies during reset must not reach anyone.
    bus3.m_cyc_i = 3'b111; bus3.m_stb_i = 3'b111; bus3.s_ack_i = 1'b1;
    bus2.m_cyc_i = 2'b11; bus2.s_err_i = 1'b1;
    #1;
    checks++;
    if (obs3() !== exp3()) begin
      errors++; $display("FAIL reset_view3 got=%h want=%h", obs3(), exp3());
    end
    checks++;
    if (obs2() !== exp2()) begin
      errors++; $display("FAIL reset_view2 got=%h want=%h", obs2(), exp2());
    end
    checks++;
    if (dp3_obs() !== dp3_exp()) begin
      errors++; $display("FAIL reset_dp3 got=%h want=%h", dp3_obs(), dp3_exp());
    end
    tick();
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single();
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) begin
        bus3.m_cyc_i = 3'b001; bus3.m_stb_i = 3'b001;
        bus2.m_cyc_i = 2'b01;  bus2.m_stb_i = 2'b01;
        bus3.m_adr_i[0] = 32'hA5A5_0000; bus3.m_adr_i[1] = 32'h5A5A_0000;
      end
      if (c == 5) begin
        bus3.m_cyc_i = '0; bus3.m_stb_i = '0; bus2.m_cyc_i = '0; bus2.m_stb_i = '0;
      end
      bus3.s_ack_i = (c == 3); bus2.s_ack_i = (c == 3);
      #1;
      checks++;
      if (obs3() !== exp3()) begin
        errors++; $display("FAIL single_view3 c=%0d got=%h want=%h", c, obs3(), exp3());
      end
      checks++;
      if (obs2() !== exp2()) begin
        errors++; $display("FAIL single_view2 c=%0d got=%h want=%h", c, obs2(), exp2());
      end
      checks++;
      if (dp3_obs() !== dp3_exp()) begin
        errors++; $display("FAIL single_dp3 c=%0d got=%h want=%h", c, dp3_obs(), dp3_exp());
      end
      if (c == 1) begin
        checks++;
        if ({bus2.grant_o, bus2.s_cyc_o} !== 3'b011) begin
          errors++; $display("FAIL single_grant c=1 got=%b want=011", {bus2.grant_o, bus2.s_cyc_o});
        end
      end
      checks++;
      if (bus2.m_ack_o !== ((c == 3) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL single_ack c=%0d got=%b", c, bus2.m_ack_o);
      end
      tick();
    end
    bus3.s_ack_i = 1'b0; bus2.s_ack_i = 1'b0;
  endtask

  task automatic test_handover();
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      if (c == 0) begin bus2.m_cyc_i = 2'b11; bus2.m_stb_i = 2'b11; end
      if (c == 4) begin bus2.m_cyc_i = 2'b10; bus2.m_stb_i = 2'b10; end
      bus2.s_ack_i = (c == 2) || (c == 6);
      #1;
      checks++;
      if (obs2() !== exp2()) begin
        errors++; $display("FAIL handover_view2 c=%0d got=%h want=%h", c, obs2(), exp2());
      end
      if (c >= 1) begin
        checks++;
        if (bus2.grant_o !== ((c >= 5) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL handover_grant c=%0d got=%b", c, bus2.grant_o);
        end
      end
      if (c < 5) begin
        checks++;
        if (bus2.m_ack_o[1] !== 1'b0) begin
          errors++; $display("FAIL handover_early_ack c=%0d got=%b want=0", c, bus2.m_ack_o[1]);
        end
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_fairness();
    logic [2:0] exp_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    bus3.m_cyc_i = 3'b111; bus3.m_stb_i = 3'b111;
    tick();
    for (int n = 0; n < 4; n++) begin
      #1;
      checks++;
      if (bus3.grant_o !== exp_seq[n]) begin
        errors++; $display("FAIL fair_grant n=%0d got=%b want=%b", n, bus3.grant_o, exp_seq[n]);
      end
      bus3.s_ack_i = 1'b1;
      #1;
      checks++;
      if (obs3() !== exp3()) begin
        errors++; $display("FAIL fair_view3 n=%0d got=%h want=%h", n, obs3(), exp3());
      end
      tick();
      bus3.s_ack_i = 1'b0;
      bus3.m_cyc_i = 3'b111 & ~(3'b001 << m3.owner);
      #1;
      checks++;
      if (obs3() !== exp3()) begin
        errors++; $display("FAIL fair_release n=%0d got=%h want=%h", n, obs3(), exp3());
      end
      tick();
      bus3.m_cyc_i = 3'b111;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_lock();
    logic [2:0] cti_now;
    do_reset();
    bus3.m_cyc_i = 3'b001; bus3.m_stb_i = 3'b001; bus3.m_bte_i[0] = 2'b01;
    tick();
    for (int b = 0; b < 4; b++) begin
      cti_now = (b == 3) ? 3'b111 : 3'b010;
      bus3.m_cti_i[0] = cti_now;
      bus3.m_adr_i[0] = 32'h4000_0000 + 32'(b * 4);
      if (b == 1) begin bus3.m_cyc_i = 3'b011; bus3.m_stb_i = 3'b011; end
      bus3.s_ack_i = 1'b1;
      #1;
      checks++;
      if ({bus3.grant_o, bus3.s_cti_o, bus3.s_bte_o} !== {3'b001, cti_now, 2'b01}) begin
        errors++; $display("FAIL lock_beat b=%0d got=%b want=%b", b,
                           {bus3.grant_o, bus3.s_cti_o, bus3.s_bte_o}, {3'b001, cti_now, 2'b01});
      end
      checks++;
      if (dp3_obs() !== dp3_exp()) begin
        errors++; $display("FAIL lock_dp3 b=%0d got=%h want=%h", b, dp3_obs(), dp3_exp());
      end
      tick();
    end
    bus3.s_ack_i = 1'b0; bus3.m_cyc_i = 3'b010; bus3.m_stb_i = 3'b010;
    #1;
    checks++;
    if (bus3.grant_o !== 3'b001) begin
      errors++; $display("FAIL lock_hold got=%b want=001", bus3.grant_o);
    end
    tick();
    #1;
    checks++;
    if (bus3.grant_o !== 3'b010) begin
      errors++; $display("FAIL lock_handover got=%b want=010", bus3.grant_o);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout();
    int pulses = 0;
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      if (c == 0) begin bus3.m_cyc_i = 3'b001; bus3.m_stb_i = 3'b001; end
      bus3.s_ack_i = (c == 10);
      #1;
      checks++;
      if (obs3() !== exp3()) begin
        errors++; $display("FAIL timeout_view3 c=%0d got=%h want=%h", c, obs3(), exp3());
      end
      if (c >= 1 && c <= 8 && bus3.m_err_o != 3'b000) pulses++;
      if (c >= 1) begin
        checks++;
        if ({bus3.m_err_o, bus3.s_stb_o} !== ((c == 5) ? 4'b0010 : 4'b0001)) begin
          errors++; $display("FAIL timeout_err c=%0d got=%b want=%b", c,
                             {bus3.m_err_o, bus3.s_stb_o}, (c == 5) ? 4'b0010 : 4'b0001);
        end
      end
      if (c == 10) begin
        checks++;
        if ({bus3.m_ack_o, bus3.m_err_o} !== 6'b001000) begin
          errors++; $display("FAIL timeout_ack_wins got=%b want=001000", {bus3.m_ack_o, bus3.m_err_o});
        end
      end
      tick();
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL timeout_pulses got=%0d want=1", pulses);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_no_watchdog();
    int bad = 0;
    do_reset();
    bus2.m_cyc_i = 2'b01; bus2.m_stb_i = 2'b01;
    tick();
    for (int c = 0; c < 300; c++) begin
      #1;
      if (bus2.m_err_o !== 2'b00 || bus2.s_stb_o !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL nowdog_err got=%0d bad cycles want=0", bad);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus3.m_cyc_i = 3'b110; bus3.m_stb_i = 3'b110;
    tick();
    tick();
    bus3.s_ack_i = 1'b1;
    #1;
    rst = 1'b1;
    m3 = mdl_reset(3);
    m2 = mdl_reset(2);
    #1;
    checks++;
    if ({bus3.grant_o, bus3.s_cyc_o, bus3.m_ack_o, bus3.m_err_o} !== 10'b0) begin
      errors++; $display("FAIL resetmid_async got=%b want=0",
                         {bus3.grant_o, bus3.s_cyc_o, bus3.m_ack_o, bus3.m_err_o});
    end
    checks++;
    if (obs3() !== exp3()) begin
      errors++; $display("FAIL resetmid_view3 got=%h want=%h", obs3(), exp3());
    end
    tick();
    rst = 1'b0;
    bus3.s_ack_i = 1'b0; bus3.m_cyc_i = 3'b111; bus3.m_stb_i = 3'b111;
    tick();
    #1;
    checks++;
    if (bus3.grant_o !== 3'b001) begin
      errors++; $display("FAIL resetmid_first got=%b want=001", bus3.grant_o);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [2:0] c3 = bus3.m_cyc_i;
      logic [1:0] c2 = bus2.m_cyc_i;
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 5) == 0) c3[i] = ~c3[i];
      for (int i = 0; i < 2; i++) if ($urandom_range(0, 5) == 0) c2[i] = ~c2[i];
      bus3.m_cyc_i = c3; bus3.m_stb_i = c3 & 3'($urandom());
      bus2.m_cyc_i = c2; bus2.m_stb_i = c2 & 2'($urandom());
      bus3.s_ack_i = ($urandom_range(0, 3) == 0);
      bus3.s_err_i = ($urandom_range(0, 15) == 0);
      bus3.s_rty_i = ($urandom_range(0, 15) == 0);
      bus2.s_ack_i = ($urandom_range(0, 3) == 0);
      bus2.s_err_i = ($urandom_range(0, 15) == 0);
      bus2.s_rty_i = ($urandom_range(0, 15) == 0);
      rand_fields();
      #1;
      checks++;
      if (obs3() !== exp3()) begin
        errors++; $display("FAIL random_view3 c=%0d got=%h want=%h", c, obs3(), exp3());
      end
      checks++;
      if (dp3_obs() !== dp3_exp()) begin
        errors++; $display("FAIL random_dp3 c=%0d got=%h want=%h", c, dp3_obs(), dp3_exp());
      end
      checks++;
      if (obs2() !== exp2()) begin
        errors++; $display("FAIL random_view2 c=%0d got=%h want=%h", c, obs2(), exp2());
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    m3 = mdl_reset(3);
    m2 = mdl_reset(2);
    clear_inputs();
    test_reset();
    test_single();
    test_handover();
    test_fairness();
    test_lock();
    test_timeout();
    test_no_watchdog();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
